jtdd_mcu_link: RTL and testbench

- Main-CPU end of the main-CPU/MCU link in the Double Dragon core; counterpart to the MCU-side wrapper.
- Drives the MCU halt request and NMI strobe, and gates main-CPU access to the dual-port shared RAM so writes only land while the MCU is halted.
- Latches the MCU-to-main interrupt line into a main-CPU IRQ with software acknowledge.
- Sits between the main CPU address decoder and the MCU wrapper.

---
 rtl/jtdd_mcu_link.sv | 187 ++++++++++++++++++
 tb/tb_jtdd_mcu_link.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_mcu_link.sv
// Main-CPU side of the Double Dragon main/MCU link: halt handshake, NMI strobe,
// shared-RAM access gating with stall timeout, and the MCU->main IRQ latch.
// Optional JTDD_MCU_AUTOHALT_EN: a shared-RAM access from RUN requests the halt itself.
module jtdd_mcu_link #(
  parameter int NMI_LEN = 4,
  parameter int TOUT    = 1023,
  parameter int AW      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_cen,
  input  logic       ctrl_cs,
  input  logic       ack_cs,
  input  logic       stat_cs,
  input  logic       shared_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] stat_dout,
  output logic       cpu_waitn,
  output logic       cpu_irqn,
  output logic       mcu_halt,
  input  logic       mcu_halted,
  output logic       mcu_nmi_set,
  input  logic       mcu_irqmain,
  output logic       com_cs
);

  typedef enum logic [1:0] {ST_RUN, ST_HREQ, ST_HALTED, ST_RELEASE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] st_onehot;
  logic       hreq_reg;
  logic       hreq_sw;
  logic       hreq;
  logic [3:0] nmi_cnt_reg;
  logic [9:0] stall_cnt_reg;
  logic       waitn_reg;
  logic       fail_reg;
  logic       tout_reg;
  logic       timeout_hit;
  logic       irq_reg;
  logic       irq_prev_reg;
  logic       ctrl_wr;
  logic       ack_wr;

  // AW sizes the RAM on the MCU side; this end only qualifies the select.
  localparam int unused_aw = AW;
  logic unused_dout;
  assign unused_dout = &{1'b0, cpu_dout[6:2]};

  assign ctrl_wr = ctrl_cs & ~cpu_wrn & cpu_cen;
  assign ack_wr  = ack_cs & ~cpu_wrn & cpu_cen;
  // The written halt bit acts in the write cycle so mcu_halt rises right after it.
  assign hreq_sw = ctrl_wr ? cpu_dout[0] : hreq_reg;

`ifdef JTDD_MCU_AUTOHALT_EN
  logic       auto_reg;
  logic [2:0] auto_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_reg     <= 1'b0;
      auto_cnt_reg <= 3'd0;
    end else if (shared_cs && (state_reg == ST_RUN || auto_reg)) begin
      auto_reg     <= 1'b1;
      auto_cnt_reg <= 3'd0;
    end else if (auto_reg && !shared_cs) begin
      if (auto_cnt_reg == 3'd7) auto_reg <= 1'b0;
      auto_cnt_reg <= auto_cnt_reg + 3'd1;
    end
  end

  assign hreq = hreq_sw | auto_reg | (shared_cs & (state_reg == ST_RUN));
`else
  assign hreq = hreq_sw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      hreq_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ctrl_wr) hreq_reg <= cpu_dout[0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:     if (hreq) state_next = ST_HREQ;
      ST_HREQ:    if (mcu_halted) state_next = ST_HALTED;
                  else if (!hreq) state_next = ST_RELEASE;
      ST_HALTED:  if (!hreq) state_next = ST_RELEASE;
                  else if (!mcu_halted) state_next = ST_HREQ;
      ST_RELEASE: if (!mcu_halted) state_next = ST_RUN;
                  else if (hreq) state_next = ST_HREQ;
      default:    state_next = ST_RUN;
    endcase
  end

  always_comb begin
    st_onehot = 4'b0001;
    mcu_halt  = 1'b0;
    case (state_reg)
      ST_RUN:     st_onehot = 4'b0001;
      ST_HREQ:    begin st_onehot = 4'b0010; mcu_halt = 1'b1; end
      ST_HALTED:  begin st_onehot = 4'b0100; mcu_halt = 1'b1; end
      ST_RELEASE: st_onehot = 4'b1000;
      default:    st_onehot = 4'b0001;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_cnt_reg <= 4'd0;
    end else if (ctrl_wr && cpu_dout[1]) begin
      nmi_cnt_reg <= 4'(NMI_LEN);
    end else if (nmi_cnt_reg != 4'd0) begin
      nmi_cnt_reg <= nmi_cnt_reg - 4'd1;
    end
  end

  assign mcu_nmi_set = (nmi_cnt_reg != 4'd0);

  // A stalled access that outlives TOUT is abandoned: the CPU is released and the write is dropped.
  assign timeout_hit = shared_cs & (state_reg != ST_HALTED) & ~fail_reg
                     & (stall_cnt_reg == 10'(TOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= 10'd0;
      waitn_reg     <= 1'b1;
      fail_reg      <= 1'b0;
    end else if (!shared_cs) begin
      stall_cnt_reg <= 10'd0;
      waitn_reg     <= 1'b1;
      fail_reg      <= 1'b0;
    end else if (state_reg == ST_HALTED || fail_reg) begin
      stall_cnt_reg <= 10'd0;
      waitn_reg     <= 1'b1;
    end else if (timeout_hit) begin
      stall_cnt_reg <= 10'd0;
      waitn_reg     <= 1'b1;
      fail_reg      <= 1'b1;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + 10'd1;
      waitn_reg     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tout_reg <= 1'b0;
    end else if (timeout_hit) begin
      tout_reg <= 1'b1;
    end else if (ctrl_wr && cpu_dout[7]) begin
      tout_reg <= 1'b0;
    end
  end

  assign cpu_waitn = waitn_reg;
  assign com_cs    = shared_cs & (state_reg == ST_HALTED) & ~fail_reg;

  // A new edge outranks a simultaneous acknowledge so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_reg      <= 1'b0;
      irq_prev_reg <= 1'b0;
    end else begin
      irq_prev_reg <= mcu_irqmain;
      if (mcu_irqmain && !irq_prev_reg) irq_reg <= 1'b1;
      else if (ack_wr) irq_reg <= 1'b0;
    end
  end

  assign cpu_irqn = ~irq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dout <= 8'd0;
    end else begin
      stat_dout <= stat_cs ? {st_onehot, tout_reg, mcu_nmi_set, irq_reg, st_onehot[2]} : 8'd0;
    end
  end

endmodule

// File: tb/tb_jtdd_mcu_link.sv
// Scoreboard bench for jtdd_mcu_link: a cycle-level behavioural model queues the
// expected outputs for every clock period and a negedge monitor compares them.
module tb_jtdd_mcu_link;
  localparam int NMI_LEN = 4;
  localparam int TOUT    = 1023;

  logic       clk = 1'b0;
  logic       rst, cpu_cen, ctrl_cs, ack_cs, stat_cs, shared_cs, cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] stat_dout;
  logic       cpu_waitn, cpu_irqn, mcu_halt, mcu_halted, mcu_nmi_set, mcu_irqmain, com_cs;

  always #5 clk = ~clk;

  jtdd_mcu_link #(.NMI_LEN(NMI_LEN), .TOUT(TOUT), .AW(9)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .ctrl_cs(ctrl_cs), .ack_cs(ack_cs),
    .stat_cs(stat_cs), .shared_cs(shared_cs), .cpu_wrn(cpu_wrn), .cpu_dout(cpu_dout),
    .stat_dout(stat_dout), .cpu_waitn(cpu_waitn), .cpu_irqn(cpu_irqn),
    .mcu_halt(mcu_halt), .mcu_halted(mcu_halted), .mcu_nmi_set(mcu_nmi_set),
    .mcu_irqmain(mcu_irqmain), .com_cs(com_cs)
  );

  typedef struct packed {
    logic       halt;
    logic       nmi;
    logic       waitn;
    logic       irqn;
    logic       com;
    logic [7:0] stat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: link phase, software halt level, NMI as "edges since last
  // NMI write", access age in stalled cycles, IRQ latch and timeout flag.
  typedef enum int {M_RUN = 0, M_HREQ = 1, M_HALTED = 2, M_REL = 3} mst_e;
  mst_e         m_st;
  bit           m_hreq, m_latch, m_prev, m_fail, m_tout;
  int           m_age;
  longint       n_done = 0;
  longint       m_last_nmi = -1000;
  byte unsigned m_stat;

  function automatic bit m_nmi();
    return (n_done - m_last_nmi) < NMI_LEN;
  endfunction

  task automatic model_step();
    bit wr_c, ack, hq, tout_hit, rise;
    int st;
    if (rst) begin
      m_st = M_RUN; m_hreq = 0; m_latch = 0; m_prev = 0; m_fail = 0; m_tout = 0;
      m_age = 0; m_stat = 0; n_done++; m_last_nmi = n_done - 1000;
      return;
    end
    wr_c = ctrl_cs && !cpu_wrn && cpu_cen;
    ack  = ack_cs && !cpu_wrn && cpu_cen;
    st = (16 << int'(m_st)) | (m_tout ? 8 : 0) | (m_nmi() ? 4 : 0) | (m_latch ? 2 : 0)
       | (m_st == M_HALTED ? 1 : 0);
    m_stat = stat_cs ? 8'(st) : 8'd0;
    tout_hit = 0;
    if (!shared_cs) begin m_age = 0; m_fail = 0; end
    else if (m_st == M_HALTED || m_fail) m_age = 0;
    else if (m_age == TOUT) begin m_age = 0; m_fail = 1; tout_hit = 1; end
    else m_age++;
    if (tout_hit) m_tout = 1;
    else if (wr_c && cpu_dout[7]) m_tout = 0;
    rise    = mcu_irqmain && !m_prev;
    m_latch = rise || (m_latch && !ack);
    m_prev  = mcu_irqmain;
    hq = wr_c ? cpu_dout[0] : m_hreq;
    m_hreq = hq;
    case (m_st)
      M_RUN:    if (hq) m_st = M_HREQ;
      M_HREQ:   if (mcu_halted) m_st = M_HALTED; else if (!hq) m_st = M_REL;
      M_HALTED: if (!hq) m_st = M_REL; else if (!mcu_halted) m_st = M_HREQ;
      default:  if (!mcu_halted) m_st = M_RUN; else if (hq) m_st = M_HREQ;
    endcase
    n_done++;
    if (wr_c && cpu_dout[1]) m_last_nmi = n_done;
  endtask

  // Queue what the DUT must show during this period, then advance one clock.
  task automatic tick();
    exp_t e;
    e.halt  = (m_st == M_HREQ || m_st == M_HALTED);
    e.nmi   = m_nmi();
    e.waitn = (m_age == 0);
    e.irqn  = !m_latch;
    e.com   = shared_cs && (m_st == M_HALTED) && !m_fail;
    e.stat  = m_stat;
    exp_q.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, want, $time);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mcu_halt",    {7'd0, mcu_halt},    {7'd0, e.halt});
        check("mcu_nmi_set", {7'd0, mcu_nmi_set}, {7'd0, e.nmi});
        check("cpu_waitn",   {7'd0, cpu_waitn},   {7'd0, e.waitn});
        check("cpu_irqn",    {7'd0, cpu_irqn},    {7'd0, e.irqn});
        check("com_cs",      {7'd0, com_cs},      {7'd0, e.com});
        check("stat_dout",   stat_dout,           e.stat);
      end
    end
  end

  task automatic idle();
    cpu_cen = 1; ctrl_cs = 0; ack_cs = 0; shared_cs = 0; cpu_wrn = 1; cpu_dout = 8'h00;
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    $display("txn ctrl write %02h at %0t", d, $time);
    ctrl_cs = 1; cpu_wrn = 0; cpu_dout = d;
    tick();
    ctrl_cs = 0; cpu_wrn = 1;
  endtask

  task automatic wr_ack();
    $display("txn irq ack at %0t", $time);
    ack_cs = 1; cpu_wrn = 0;
    tick();
    ack_cs = 0; cpu_wrn = 1;
  endtask

  initial begin
    idle();
    rst = 1; stat_cs = 0; mcu_halted = 0; mcu_irqmain = 0;
    @(posedge clk);
    model_step();
    #1;
    repeat (3) tick();
    rst = 0;
    tick();

    // halt handshake with status readback
    stat_cs = 1;
    wr_ctrl(8'h01);
    repeat (4) tick();
    mcu_halted = 1;
    repeat (4) tick();

    // NMI pulse, then a restart two cycles into a pulse
    wr_ctrl(8'h03);
    repeat (6) tick();
    wr_ctrl(8'h03);
    tick();
    wr_ctrl(8'h03);
    repeat (7) tick();

    // shared write while halted goes straight through
    $display("txn shared write 5a while halted at %0t", $time);
    shared_cs = 1; cpu_wrn = 0; cpu_dout = 8'h5A;
    repeat (2) tick();
    idle();
    tick();

    // release, then a shared access that times out
    wr_ctrl(8'h00);
    mcu_halted = 0;
    repeat (3) tick();
    $display("txn shared write while running (timeout) at %0t", $time);
    shared_cs = 1; cpu_wrn = 0; cpu_dout = 8'hA5;
    repeat (TOUT + 6) tick();
    idle();
    repeat (2) tick();
    wr_ctrl(8'h80);
    repeat (2) tick();

    // IRQ edge, edge colliding with ack, lone ack
    $display("txn mcu irq edge at %0t", $time);
    mcu_irqmain = 1;
    repeat (2) tick();
    mcu_irqmain = 0;
    repeat (2) tick();
    mcu_irqmain = 1;
    wr_ack();
    repeat (2) tick();
    wr_ack();
    repeat (2) tick();
    mcu_irqmain = 0;

    // reset while halted with the CPU still stalled
    wr_ctrl(8'h01);
    $display("txn shared access then reset at %0t", $time);
    shared_cs = 1;
    repeat (3) tick();
    mcu_halted = 1;
    tick();
    rst = 1;
    mcu_irqmain = 1;
    tick();
    rst = 0;
    mcu_irqmain = 0;
    idle();
    mcu_halted = 0;
    repeat (3) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst      = ($urandom_range(0, 299) == 0);
      cpu_cen  = ($urandom_range(0, 3) != 0);
      cpu_wrn  = ($urandom_range(0, 2) != 0);
      r        = $urandom_range(0, 19);
      ctrl_cs  = (r < 2);
      ack_cs   = (r == 2);
      stat_cs  = $urandom_range(0, 1);
      cpu_dout = 8'($urandom);
      if ($urandom_range(0, 9) == 0) shared_cs = ~shared_cs;
      if ($urandom_range(0, 3) == 0) mcu_halted = (m_st == M_HREQ || m_st == M_HALTED);
      if ($urandom_range(0, 7) == 0) mcu_irqmain = ~mcu_irqmain;
      tick();
    end
    idle();
    rst = 0;
    tick();

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
